// File: rtl/ping_pong_pkg.sv
// ping_pong_pkg
//   Shared definitions for the ping-pong counter interface: default widths,
//   direction encoding and the monitor's lock-state encoding.
//   No ports (package).
package ping_pong_pkg;

    localparam int PP_WIDTH = 4;  // default counter value width
    localparam int PP_CNT_W = 8;  // default width of the saturating event counters

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } pp_state_t;

endpackage : ping_pong_pkg

// File: rtl/ping_pong_predictor.sv
// ping_pong_predictor
//   Combinational next-step model of the ping-pong counter. This is the only
//   place that encodes the transition rules.
//   Ports:
//     i_o          previous counter value
//     i_d          previous direction (1 = up, 0 = down)
//     i_e          enable that was applied with the previous value
//     o_next_o     value the counter must show next
//     o_next_d     direction the counter must show next
//     o_is_bounce  the step from (i_o, i_d) is a turnaround
module ping_pong_predictor
    import ping_pong_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH
) (
    input  logic [WIDTH-1:0] i_o,
    input  logic             i_d,
    input  logic             i_e,
    output logic [WIDTH-1:0] o_next_o,
    output logic             o_next_d,
    output logic             o_is_bounce
);

    localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        o_next_o    = i_o;
        o_next_d    = i_d;
        o_is_bounce = 1'b0;
        if (i_e) begin
            if (i_d == DIR_UP) begin
                if (i_o == MAX_V) begin
                    // Top turnaround: skip straight to MAX-1 heading down.
                    o_next_o    = MAX_V - ONE_V;
                    o_next_d    = DIR_DOWN;
                    o_is_bounce = 1'b1;
                end else begin
                    o_next_o = i_o + ONE_V;
                end
            end else begin
                if (i_o == '0) begin
                    // Bottom turnaround: 0 goes to 1 heading up.
                    o_next_o    = ONE_V;
                    o_next_d    = DIR_UP;
                    o_is_bounce = 1'b1;
                end else begin
                    o_next_o = i_o - ONE_V;
                end
            end
        end
    end

endmodule : ping_pong_predictor

// File: rtl/ping_pong_monitor.sv
// ping_pong_monitor
//   Receive-side checker for a ping-pong counter. Registers every
//   (out, direction, enable) sample, predicts the next sample from it and
//   compares. Locks on the first legal sample, flags illegal steps and counts
//   turnarounds and errors with saturating counters.
//   Ports:
//     i_clk, i_rst_n    clock, asynchronous active-low reset
//     i_enable          enable the counter sees this cycle
//     i_direction       counter direction (1 = up, 0 = down)
//     i_out             counter value
//     o_locked          monitor synchronised and checking
//     o_error           one-cycle pulse for each illegal sample
//     o_exp_out/dir     prediction for the most recently registered sample
//     o_bounce_count    turnarounds seen while locked (saturating)
//     o_err_count       errors detected (saturating)
//   Outputs for a sample taken on edge k are visible after edge k.
module ping_pong_monitor
    import ping_pong_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH,
    parameter int CNT_W = PP_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_direction,
    input  logic [WIDTH-1:0] i_out,
    output logic             o_locked,
    output logic             o_error,
    output logic [WIDTH-1:0] o_exp_out,
    output logic             o_exp_dir,
    output logic [CNT_W-1:0] o_bounce_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam logic [WIDTH-1:0] MAX_V   = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pp_state_t        r_state;
    pp_state_t        w_state_nxt;

    logic [WIDTH-1:0] r_o;
    logic             r_d;
    logic             r_e;

    logic             r_error;
    logic [WIDTH-1:0] r_exp_out;
    logic             r_exp_dir;
    logic [CNT_W-1:0] r_bounce_count;
    logic [CNT_W-1:0] r_err_count;

    logic [WIDTH-1:0] w_pred_o;
    logic             w_pred_d;
    logic             w_pred_bounce;
    logic             w_illegal;
    logic             w_match;
    logic             w_err_evt;
    logic             w_bounce_evt;

    ping_pong_predictor #(.WIDTH(WIDTH)) u_pred (
        .i_o         (r_o),
        .i_d         (r_d),
        .i_e         (r_e),
        .o_next_o    (w_pred_o),
        .o_next_d    (w_pred_d),
        .o_is_bounce (w_pred_bounce)
    );

    // (MAX, down) can never be produced by a healthy counter.
    assign w_illegal = (i_out == MAX_V) && (i_direction == DIR_DOWN);
    assign w_match   = (i_out == w_pred_o) && (i_direction == w_pred_d);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the per-sample error/bounce events.
    always_comb begin
        w_state_nxt  = r_state;
        w_err_evt    = 1'b0;
        w_bounce_evt = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_illegal) begin
                    w_err_evt = 1'b1;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_illegal || !w_match) begin
                    // Drop lock; this sample is registered and serves as the
                    // reference for the resync attempt on the next sample.
                    w_err_evt   = 1'b1;
                    w_state_nxt = ST_UNLOCKED;
                end else begin
                    w_bounce_evt = w_pred_bounce;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
            end
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        o_locked = (r_state == ST_LOCKED);
    end

    // Sample registers, prediction outputs and saturating counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_o            <= '0;
            r_d            <= 1'b0;
            r_e            <= 1'b0;
            r_error        <= 1'b0;
            r_exp_out      <= '0;
            r_exp_dir      <= DIR_UP;
            r_bounce_count <= '0;
            r_err_count    <= '0;
        end else begin
            r_o       <= i_out;
            r_d       <= i_direction;
            r_e       <= i_enable;
            r_error   <= w_err_evt;
            r_exp_out <= w_pred_o;
            r_exp_dir <= w_pred_d;
            if (w_bounce_evt && (r_bounce_count != CNT_MAX)) begin
                r_bounce_count <= r_bounce_count + CNT_ONE;
            end
            if (w_err_evt && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_ONE;
            end
        end
    end

    assign o_error        = r_error;
    assign o_exp_out      = r_exp_out;
    assign o_exp_dir      = r_exp_dir;
    assign o_bounce_count = r_bounce_count;
    assign o_err_count    = r_err_count;

endmodule : ping_pong_monitor

// File: tb/tb_ping_pong_monitor.sv
// tb_ping_pong_monitor
//   Directed bench for ping_pong_monitor: a hand-computed vector table for the
//   mismatch / illegal-pair / relock corners, plus streamed counter runs,
//   an asynchronous mid-count reset and error-counter saturation.
module tb_ping_pong_monitor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             direction = 1'b1;
    logic [WIDTH-1:0] out = '0;
    logic             locked;
    logic             error;
    logic [WIDTH-1:0] exp_out;
    logic             exp_dir;
    logic [CNT_W-1:0] bounce_count;
    logic [CNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    // Stimulus-side counter state and expected bounce total.
    logic [WIDTH-1:0] c_o;
    logic             c_d;
    int               exp_bc;

    typedef struct {
        logic             en;
        logic             d;
        logic [WIDTH-1:0] o;
        logic             lk;
        logic             er;
        logic [WIDTH-1:0] xo;
        logic             xd;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] ec;
    } vec_t;

    vec_t tbl[18];

    ping_pong_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_direction    (direction),
        .i_out          (out),
        .o_locked       (locked),
        .o_error        (error),
        .o_exp_out      (exp_out),
        .o_exp_dir      (exp_dir),
        .o_bounce_count (bounce_count),
        .o_err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " locked"},  32'(locked), 32'd0);
        check({tag, " error"},   32'(error), 32'd0);
        check({tag, " exp_out"}, 32'(exp_out), 32'd0);
        check({tag, " exp_dir"}, 32'(exp_dir), 32'd1);
        check({tag, " bounce"},  32'(bounce_count), 32'd0);
        check({tag, " errcnt"},  32'(err_count), 32'd0);
    endtask

    // Legal counter step used to generate stimulus; reports turnarounds.
    task automatic cnt_advance(input logic en, output bit bounced);
        bounced = 1'b0;
        if (en) begin
            if (c_d) begin
                if (c_o == 4'd15) begin c_o = 4'd14; c_d = 1'b0; bounced = 1'b1; end
                else c_o = c_o + 4'd1;
            end else begin
                if (c_o == 4'd0) begin c_o = 4'd1; c_d = 1'b1; bounced = 1'b1; end
                else c_o = c_o - 4'd1;
            end
        end
    endtask

    // Feed n samples of a healthy counter. The monitor must be (or become, on
    // the first sample) locked and never flag an error.
    task automatic run_stream(input int n, input bit alternate, input bit skip_first_exp);
        bit b;
        bit pend;
        pend = 1'b0;
        for (int i = 0; i < n; i++) begin
            enable    = alternate ? ((i % 2) == 0) : 1'b1;
            out       = c_o;
            direction = c_d;
            step();
            if (pend) exp_bc++;
            check("stream error",  32'(error), 32'd0);
            check("stream locked", 32'(locked), 32'd1);
            check("stream bounce", 32'(bounce_count), 32'(exp_bc));
            if (!(skip_first_exp && i == 0)) begin
                check("stream exp_out", 32'(exp_out), 32'(out));
                check("stream exp_dir", 32'(exp_dir), 32'(direction));
            end
            cnt_advance(enable, b);
            pend = b;
        end
    endtask

    task automatic set_row(input int k, input int en, input int d, input int o, input int lk,
                           input int er, input int xo, input int xd, input int bc, input int ec);
        tbl[k].en = 1'(en);  tbl[k].d  = 1'(d);  tbl[k].o  = 4'(o);
        tbl[k].lk = 1'(lk);  tbl[k].er = 1'(er); tbl[k].xo = 4'(xo);
        tbl[k].xd = 1'(xd);  tbl[k].bc = 8'(bc); tbl[k].ec = 8'(ec);
    endtask

    initial begin
        //        en d  o   lk er xo xd bc ec
        set_row(0,  1, 1, 0,  1, 0, 0, 0, 0, 0);  // lock on counter reset pair
        set_row(1,  1, 1, 1,  1, 0, 1, 1, 0, 0);
        set_row(2,  1, 1, 2,  1, 0, 2, 1, 0, 0);
        set_row(3,  1, 1, 3,  1, 0, 3, 1, 0, 0);
        set_row(4,  1, 1, 4,  1, 0, 4, 1, 0, 0);
        set_row(5,  1, 1, 5,  1, 0, 5, 1, 0, 0);
        set_row(6,  1, 1, 7,  0, 1, 6, 1, 0, 1);  // 5 -> 7 skip
        set_row(7,  1, 1, 8,  1, 0, 8, 1, 0, 1);  // relock, error gone
        set_row(8,  1, 1, 9,  1, 0, 9, 1, 0, 1);
        set_row(9,  1, 0, 15, 0, 1, 10, 1, 0, 2); // (MAX,0) while locked
        set_row(10, 1, 0, 15, 0, 1, 14, 0, 0, 3); // (MAX,0) while unlocked
        set_row(11, 1, 0, 15, 0, 1, 14, 0, 0, 4);
        set_row(12, 1, 1, 15, 1, 0, 14, 0, 0, 4); // legal pair locks
        set_row(13, 1, 0, 14, 1, 0, 14, 0, 1, 4); // top bounce counted
        set_row(14, 0, 0, 13, 1, 0, 13, 0, 1, 4);
        set_row(15, 0, 0, 13, 1, 0, 13, 0, 1, 4); // held
        set_row(16, 1, 0, 13, 1, 0, 13, 0, 1, 4);
        set_row(17, 1, 0, 12, 1, 0, 12, 0, 1, 4);

        // Reset values.
        rst_n = 1'b0;
        step();
        step();
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Continuous enable: 0..15..0..1, two bounces over 31 steps.
        c_o = 4'd0; c_d = 1'b1; exp_bc = 0;
        run_stream(32, 1'b0, 1'b1);
        check("run32 bounce total", 32'(bounce_count), 32'd2);
        check("run32 err total",    32'(err_count), 32'd0);

        // Alternating enable keeps lock; two more bounces.
        run_stream(64, 1'b1, 1'b0);
        check("alt bounce total", 32'(bounce_count), 32'd4);
        check("alt err total",    32'(err_count), 32'd0);

        // Table of corner cases from a fresh reset.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 18; k++) begin
            enable    = tbl[k].en;
            direction = tbl[k].d;
            out       = tbl[k].o;
            step();
            check($sformatf("row%0d locked", k),  32'(locked), 32'(tbl[k].lk));
            check($sformatf("row%0d error", k),   32'(error), 32'(tbl[k].er));
            check($sformatf("row%0d exp_out", k), 32'(exp_out), 32'(tbl[k].xo));
            check($sformatf("row%0d exp_dir", k), 32'(exp_dir), 32'(tbl[k].xd));
            check($sformatf("row%0d bounce", k),  32'(bounce_count), 32'(tbl[k].bc));
            check($sformatf("row%0d errcnt", k),  32'(err_count), 32'(tbl[k].ec));
        end

        // Continue down to 9, then reset asynchronously mid-cycle.
        c_o = 4'd11; c_d = 1'b0; exp_bc = 1;
        run_stream(3, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async reset");
        step();
        step();
        check_reset_vals("held reset");
        rst_n = 1'b1;
        c_o = 4'd0; c_d = 1'b1; exp_bc = 0;
        run_stream(6, 1'b0, 1'b1);

        // Saturation: 300 illegal samples in a row.
        for (int i = 0; i < 300; i++) begin
            enable    = 1'b1;
            direction = 1'b0;
            out       = 4'd15;
            step();
            check("sat error",  32'(error), 32'd1);
            check("sat errcnt", 32'(err_count), 32'((i + 1 > 255) ? 255 : i + 1));
        end
        check("sat locked", 32'(locked), 32'd0);
        check("sat final",  32'(err_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ping_pong_monitor
